// File: rtl/game_judger_n_pkg.sv
// rtl/game_judger_n_pkg.sv - shared encodings for the parametrised move judger
// Purpose: result codes, side codes, direction codes and FSM state type used
//          by game_judger_n and judger_line_walker.
// Ports  : none (package).
package game_judger_n_pkg;

   localparam logic [1:0] JUDGER_INVALID = 2'd0;
   localparam logic [1:0] JUDGER_VALID   = 2'd1;
   localparam logic [1:0] JUDGER_WIN     = 2'd2;

   localparam logic       SIDE_RED       = 1'b0;
   localparam logic       SIDE_GREEN     = 1'b1;

   localparam logic [1:0] DIR_H          = 2'd0;   // +x
   localparam logic [1:0] DIR_V          = 2'd1;   // +y
   localparam logic [1:0] DIR_D          = 2'd2;   // +x,+y
   localparam logic [1:0] DIR_AD         = 2'd3;   // +x,-y

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OCC,
      ST_OCC_CHK,
      ST_SCAN,
      ST_DRAIN,
      ST_DONE
   } judger_state_t;

endpackage

// File: rtl/judger_line_walker.sv
// rtl/judger_line_walker.sv - walks the 4 scan lines around a move, one cell per step
// Purpose: holds the cell index / direction counters and derives the current
//          cell coordinate plus its per-cell flags.
// Ports  : clk, rst_n      - clock, async active-low reset
//          i_step          - advance one cell; when low the walker rewinds to dir 0, first cell
//          i_pos           - move position {y,x}
//          o_coord         - current cell {y,x} (meaningless when o_offboard)
//          o_dir           - current direction code
//          o_offboard      - current cell lies outside the board
//          o_is_center     - current cell is the move itself
//          o_first         - first cell of a direction
//          o_last          - last cell of the last direction
module judger_line_walker
   import game_judger_n_pkg::*;
#(
   parameter int COORD_W = 3,
   parameter int WIN_LEN = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_step,
   input  logic [2*COORD_W-1:0] i_pos,
   output logic [2*COORD_W-1:0] o_coord,
   output logic [1:0]           o_dir,
   output logic                 o_offboard,
   output logic                 o_is_center,
   output logic                 o_first,
   output logic                 o_last
);

   localparam int L     = 2*WIN_LEN - 1;
   localparam int IDX_W = COORD_W + 1;
   // Two spare bits: pos + k spans -(N-1)..2N-2, so no wrap can alias onto the board.
   localparam int SW    = COORD_W + 2;

   logic [IDX_W-1:0]     r_idx;
   logic [1:0]           r_dir;
   logic signed [SW-1:0] w_k;
   logic signed [SW-1:0] w_x0;
   logic signed [SW-1:0] w_y0;
   logic signed [SW-1:0] w_x;
   logic signed [SW-1:0] w_y;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx <= '0;
         r_dir <= '0;
      end else if (!i_step) begin
         r_idx <= '0;
         r_dir <= '0;
      end else if (r_idx == IDX_W'(L-1)) begin
         r_idx <= '0;
         r_dir <= r_dir + 2'd1;
      end else begin
         r_idx <= r_idx + IDX_W'(1);
      end
   end

   always_comb begin
      w_k  = $signed({1'b0, r_idx}) - $signed(SW'(WIN_LEN-1));
      w_x0 = $signed({2'b00, i_pos[COORD_W-1:0]});
      w_y0 = $signed({2'b00, i_pos[2*COORD_W-1:COORD_W]});
      w_x  = w_x0;
      w_y  = w_y0;
      case (r_dir)
         DIR_H:   w_x = w_x0 + w_k;
         DIR_V:   w_y = w_y0 + w_k;
         DIR_D:   begin w_x = w_x0 + w_k; w_y = w_y0 + w_k; end
         default: begin w_x = w_x0 + w_k; w_y = w_y0 - w_k; end
      endcase
   end

   // Any bit above the coordinate field (including sign) means off-board.
   assign o_offboard  = (w_x[SW-1:COORD_W] != '0) || (w_y[SW-1:COORD_W] != '0);
   assign o_coord     = {w_y[COORD_W-1:0], w_x[COORD_W-1:0]};
   assign o_dir       = r_dir;
   assign o_is_center = (r_idx == IDX_W'(WIN_LEN-1));
   assign o_first     = (r_idx == '0);
   assign o_last      = (r_dir == DIR_AD) && (r_idx == IDX_W'(L-1));

endmodule

// File: rtl/game_judger_n.sv
// rtl/game_judger_n.sv - parametrised board move judger (occupancy + N-in-a-row)
// Purpose: checks a proposed move against the board RAM, then scans 4 lines of
//          2*WIN_LEN-1 cells around it with fixed latency, reporting INVALID,
//          VALID or WIN with the winning direction and end cell.
// Ports  : clk, rst_n      - clock, async active-low reset
//          en              - level request, held until done, then dropped
//          color, pos      - mover side and position {y,x}
//          ram_rd_addr     - board RAM read address {y,x}
//          ram_data        - board RAM data, 1-cycle read latency
//          result, done    - judgement and its valid flag (held until en low)
//          win_dir,win_end - winning direction and completing cell
module game_judger_n
   import game_judger_n_pkg::*;
#(
   parameter int COORD_W = 3,
   parameter int WIN_LEN = 5,
   parameter int CNT_W   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 color,
   input  logic [2*COORD_W-1:0] pos,
   output logic [2*COORD_W-1:0] ram_rd_addr,
   input  logic [1:0]           ram_data,
   output logic [1:0]           result,
   output logic                 done,
   output logic [1:0]           win_dir,
   output logic [2*COORD_W-1:0] win_end
);

   judger_state_t        r_state;
   judger_state_t        w_next;

   logic [2*COORD_W-1:0] w_coord;
   logic [1:0]           w_dir;
   logic                 w_offboard;
   logic                 w_is_center;
   logic                 w_first;
   logic                 w_last;

   // Tag of the cell whose data arrives this cycle.
   logic                 r_tag_valid;
   logic                 r_tag_off;
   logic                 r_tag_center;
   logic                 r_tag_first;
   logic [1:0]           r_tag_dir;
   logic [2*COORD_W-1:0] r_tag_coord;

   logic [CNT_W-1:0]     r_run;
   logic [CNT_W-1:0]     w_run_next;
   logic                 w_match;
   logic                 w_win;

   logic [1:0]           r_result;
   logic                 r_done;
   logic [1:0]           r_win_dir;
   logic [2*COORD_W-1:0] r_win_end;

   judger_line_walker #(
      .COORD_W (COORD_W),
      .WIN_LEN (WIN_LEN)
   ) u_walker (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_step      (r_state == ST_SCAN),
      .i_pos       (pos),
      .o_coord     (w_coord),
      .o_dir       (w_dir),
      .o_offboard  (w_offboard),
      .o_is_center (w_is_center),
      .o_first     (w_first),
      .o_last      (w_last)
   );

   // The move's own cell counts as the mover's stone; off-board cells never match.
   assign w_match = r_tag_center ||
                    (!r_tag_off && ((color == SIDE_RED) ? ram_data[1] : ram_data[0]));

   always_comb begin
      w_run_next = '0;
      if (w_match) begin
         w_run_next = r_tag_first ? CNT_W'(1) : r_run + CNT_W'(1);
      end
   end

   assign w_win = r_tag_valid && (w_run_next == CNT_W'(WIN_LEN));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (en && !r_done) w_next = ST_OCC;
         ST_OCC:     w_next = en ? ST_OCC_CHK : ST_IDLE;
         ST_OCC_CHK: begin
            if (!en)                   w_next = ST_IDLE;
            else if (ram_data != 2'b00) w_next = ST_DONE;
            else                       w_next = ST_SCAN;
         end
         ST_SCAN: begin
            if (!en)                   w_next = ST_IDLE;
            else if (w_win)            w_next = ST_DONE;
            else if (w_last)           w_next = ST_DRAIN;
         end
         ST_DRAIN:   w_next = en ? ST_DONE : ST_IDLE;
         ST_DONE:    if (!en) w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      ram_rd_addr = '0;
      if (r_state == ST_OCC)       ram_rd_addr = pos;
      else if (r_state == ST_SCAN) ram_rd_addr = w_coord;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag_valid  <= 1'b0;
         r_tag_off    <= 1'b0;
         r_tag_center <= 1'b0;
         r_tag_first  <= 1'b0;
         r_tag_dir    <= '0;
         r_tag_coord  <= '0;
         r_run        <= '0;
         r_result     <= JUDGER_INVALID;
         r_done       <= 1'b0;
         r_win_dir    <= '0;
         r_win_end    <= '0;
      end else begin
         r_tag_valid  <= (r_state == ST_SCAN);
         r_tag_off    <= w_offboard;
         r_tag_center <= w_is_center;
         r_tag_first  <= w_first;
         r_tag_dir    <= w_dir;
         r_tag_coord  <= w_coord;

         if (r_state == ST_OCC_CHK)  r_run <= '0;
         else if (r_tag_valid)       r_run <= w_run_next;

         r_done <= (w_next == ST_DONE);

         if ((w_next == ST_DONE) && (r_state != ST_DONE)) begin
            if (r_state == ST_OCC_CHK) begin
               r_result <= JUDGER_INVALID;
            end else if (w_win) begin
               r_result  <= JUDGER_WIN;
               r_win_dir <= r_tag_dir;
               r_win_end <= r_tag_coord;
            end else begin
               r_result <= JUDGER_VALID;
            end
         end
      end
   end

   assign result  = r_result;
   assign done    = r_done;
   assign win_dir = r_win_dir;
   assign win_end = r_win_end;

endmodule

// File: tb/tb_game_judger_n.sv
// tb/tb_game_judger_n.sv - scoreboard bench for game_judger_n at default parameters
module tb_game_judger_n;
   import game_judger_n_pkg::*;

   localparam int N = 8;
   localparam int W = 5;
   localparam int L = 2*W - 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       color = 1'b0;
   logic [5:0] pos = '0;
   logic [5:0] ram_rd_addr;
   logic [1:0] ram_data = '0;
   logic [1:0] result;
   logic       done;
   logic [1:0] win_dir;
   logic [5:0] win_end;

   game_judger_n #(.COORD_W(3), .WIN_LEN(W), .CNT_W(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .color       (color),
      .pos         (pos),
      .ram_rd_addr (ram_rd_addr),
      .ram_data    (ram_data),
      .result      (result),
      .done        (done),
      .win_dir     (win_dir),
      .win_end     (win_end)
   );

   always #5 clk = ~clk;

   logic [1:0] board [0:N-1][0:N-1];

   // Board RAM with one-cycle synchronous read.
   always @(posedge clk) ram_data <= board[ram_rd_addr[5:3]][ram_rd_addr[2:0]];

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [1:0] res;
      logic [1:0] dir;
      logic [5:0] end_c;
      int         lat;
      int         cyc;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic [1:0] last_res = JUDGER_INVALID;

   int dxt[4] = '{1, 0, 1, 1};
   int dyt[4] = '{0, 1, 1, -1};

   task automatic check(input string name, input int act, input int req);
      n_total++;
      if (act == req) n_pass++;
      else $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
   endtask

   // Reference: scan the rules directly over the board array.
   function automatic void model(input logic c, input int px, input int py, output exp_t e);
      int run;
      int x;
      int y;
      int k;
      bit m;
      e.res = JUDGER_VALID; e.dir = '0; e.end_c = '0; e.lat = 4*L + 3; e.cyc = 0;
      if (board[py][px] != 2'b00) begin
         e.res = JUDGER_INVALID; e.lat = 2;
         return;
      end
      for (int d = 0; d < 4; d++) begin
         run = 0;
         for (int i = 0; i < L; i++) begin
            k = i - (W - 1);
            x = px + k*dxt[d];
            y = py + k*dyt[d];
            if (k == 0) m = 1'b1;
            else if (x < 0 || x >= N || y < 0 || y >= N) m = 1'b0;
            else m = board[y][x][(c == SIDE_RED) ? 1 : 0];
            run = m ? run + 1 : 0;
            if (run == W) begin
               e.res = JUDGER_WIN; e.dir = 2'(d); e.end_c = {3'(y), 3'(x)};
               e.lat = d*L + i + 4;
               return;
            end
         end
      end
   endfunction

   task automatic clear_board();
      for (int y = 0; y < N; y++)
         for (int x = 0; x < N; x++)
            board[y][x] = 2'b00;
   endtask

   function automatic logic [1:0] stone(input logic c);
      return (c == SIDE_RED) ? 2'b10 : 2'b01;
   endfunction

   task automatic run_move(input logic c, input int px, input int py);
      exp_t e;
      int   n;
      model(c, px, py, e);
      @(negedge clk);
      color = c; pos = {3'(py), 3'(px)}; en = 1'b1;
      e.cyc = cyc + 1 + e.lat;
      q.push_back(e);
      n = 0;
      while (!done && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         check("done_timeout", 0, 1);
         q.delete();
      end else begin
         repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            check("done_held", done, 1);
         end
      end
      en = 1'b0;
      @(negedge clk);
      check("done_clear", done, 0);
      check("result_kept", result, e.res);
      last_res = e.res;
   endtask

   // Monitor: compare each completed judgement against the queued expectation.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done && !prev_done) begin
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("result", result, e.res);
            check("latency", cyc, e.cyc);
            if (e.res == JUDGER_WIN) begin
               check("win_dir", win_dir, e.dir);
               check("win_end", win_end, e.end_c);
            end
         end
      end
      prev_done = done;
   end

   initial begin
      int px;
      int py;
      int d;
      int s;
      int x;
      int y;
      logic c;

      clear_board();
      repeat (3) @(negedge clk);
      check("rst_result", result, JUDGER_INVALID);
      check("rst_done", done, 0);
      check("rst_win_dir", win_dir, 0);
      check("rst_win_end", win_end, 0);
      check("rst_addr", ram_rd_addr, 0);
      rst_n = 1'b1;

      // Empty board, centre move.
      run_move(SIDE_RED, 3, 3);

      // Occupied cell.
      board[5][2] = 2'b01;
      run_move(SIDE_RED, 2, 5);

      // Horizontal four plus the move.
      clear_board();
      for (int i = 0; i < 4; i++) board[4][i] = 2'b10;
      run_move(SIDE_RED, 4, 4);

      // Anti-diagonal green line, then split by a red stone.
      clear_board();
      board[7][0] = 2'b01; board[6][1] = 2'b01; board[5][2] = 2'b01; board[3][4] = 2'b01;
      run_move(SIDE_GREEN, 3, 4);
      board[5][2] = 2'b10;
      run_move(SIDE_GREEN, 3, 4);

      // Corner move, off-board masking.
      clear_board();
      board[0][1] = 2'b10; board[0][2] = 2'b10; board[0][3] = 2'b10;
      run_move(SIDE_RED, 0, 0);

      // Stones at x=6,7 must not wrap onto a run starting at x=0.
      clear_board();
      board[0][6] = 2'b10; board[0][7] = 2'b10; board[0][1] = 2'b10; board[0][2] = 2'b10;
      run_move(SIDE_RED, 0, 0);

      // Abort mid-scan: done never asserts, outputs unchanged.
      clear_board();
      @(negedge clk);
      color = SIDE_RED; pos = {3'd3, 3'd3}; en = 1'b1;
      repeat (15) @(negedge clk);
      en = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("abort_done", done, 0);
         check("abort_result", result, last_res);
      end
      run_move(SIDE_GREEN, 6, 1);

      // Asynchronous reset mid-scan.
      board[2][2] = 2'b10; board[2][3] = 2'b10; board[2][4] = 2'b10; board[2][5] = 2'b10;
      run_move(SIDE_RED, 6, 2);
      @(negedge clk);
      color = SIDE_RED; pos = {3'd1, 3'd1}; en = 1'b1;
      repeat (12) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_result", result, JUDGER_INVALID);
      check("midrst_done", done, 0);
      check("midrst_win_dir", win_dir, 0);
      check("midrst_win_end", win_end, 0);
      check("midrst_addr", ram_rd_addr, 0);
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;
      last_res = JUDGER_INVALID;

      // Randomised boards, often with a planted near-complete line.
      for (int t = 0; t < 40; t++) begin
         for (int yy = 0; yy < N; yy++)
            for (int xx = 0; xx < N; xx++) begin
               s = $urandom_range(0, 9);
               board[yy][xx] = (s < 3) ? 2'b10 : (s < 6) ? 2'b01 : 2'b00;
            end
         px = $urandom_range(0, N-1);
         py = $urandom_range(0, N-1);
         c  = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) != 0) begin
            d = $urandom_range(0, 3);
            s = $urandom_range(0, W-1);
            for (int j = 0; j < W; j++) begin
               x = px + (j - s)*dxt[d];
               y = py + (j - s)*dyt[d];
               if (j != s && x >= 0 && x < N && y >= 0 && y < N) board[y][x] = stone(c);
            end
         end
         if ($urandom_range(0, 3) != 0) board[py][px] = 2'b00;
         run_move(c, px, py);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
